// File: rtl/filter_beat_packer.sv
// Packs a stream of IN_BITS words into OUT_BITS beats, lane 0 first.
// A beat is emitted when all lanes are filled or the packet ends; unused lanes are zero.

module filter_beat_lane #(
  parameter int IN_BITS = 64,
  parameter int IDX_W   = 3,
  parameter int LANE    = 0
) (
  input  logic [IDX_W-1:0]     idx,
  input  logic [IN_BITS-1:0]   acc_word,
  input  logic [IN_BITS-1:0]   in_word,
  output logic [IN_BITS-1:0]   lane_word,
  output logic [IN_BITS/8-1:0] lane_keep
);
  localparam logic [IDX_W-1:0] L = IDX_W'(LANE);

  // Lanes above the closing word are forced to zero so stale accumulator data never leaks.
  always_comb begin
    lane_word = '0;
    lane_keep = '0;
    if (L < idx) begin
      lane_word = acc_word;
      lane_keep = '1;
    end else if (L == idx) begin
      lane_word = in_word;
      lane_keep = '1;
    end
  end
endmodule

module filter_beat_packer #(
  parameter int IN_BITS  = 64,
  parameter int OUT_BITS = 512,
  parameter int LANES    = OUT_BITS / IN_BITS
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [IN_BITS-1:0]    s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [OUT_BITS-1:0]   m_tdata,
  output logic [OUT_BITS/8-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_beats
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int KB    = IN_BITS / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [LANES-2:0][IN_BITS-1:0]  acc_q, acc_d;
  logic [LANES-1:0][IN_BITS-1:0]  acc_ext;
  logic [LANES-1:0][IN_BITS-1:0]  beat_data;
  logic [LANES-1:0][KB-1:0]       beat_keep;
  logic                           m_tvalid_q, m_tvalid_d;
  logic                           m_tlast_q, m_tlast_d;
  logic [OUT_BITS-1:0]            m_tdata_q, m_tdata_d;
  logic [OUT_BITS/8-1:0]          m_tkeep_q, m_tkeep_d;
  logic [31:0]                    stat_words_q, stat_words_d;
  logic [31:0]                    stat_beats_q, stat_beats_d;
  logic                           accept, load, out_hs;

  assign s_tready = ~m_tvalid_q | m_tready;
  assign accept   = s_tvalid & s_tready;
  assign out_hs   = m_tvalid_q & m_tready;
  assign load     = accept & ((idx_q == LAST_IDX) | s_tlast);
  assign acc_ext  = {{IN_BITS{1'b0}}, acc_q};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    filter_beat_lane #(.IN_BITS(IN_BITS), .IDX_W(IDX_W), .LANE(g)) u_lane (
      .idx       (idx_q),
      .acc_word  (acc_ext[g]),
      .in_word   (s_tdata),
      .lane_word (beat_data[g]),
      .lane_keep (beat_keep[g])
    );
  end

  always_comb begin
    idx_d        = idx_q;
    acc_d        = acc_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tkeep_d    = m_tkeep_q;
    stat_words_d = stat_words_q + 32'(accept);
    stat_beats_d = stat_beats_q + 32'(out_hs);
    for (int i = 0; i < LANES - 1; i++)
      if (accept && !load && idx_q == IDX_W'(i)) acc_d[i] = s_tdata;
    // A load overrides the handshake-driven clear, so back-to-back beats have no bubble.
    if (load) begin
      idx_d      = '0;
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_tlast;
      m_tdata_d  = beat_data;
      m_tkeep_d  = beat_keep;
    end else begin
      if (accept) idx_d = idx_q + 1'b1;
      if (out_hs) m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx_q        <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      stat_words_q <= '0;
      stat_beats_q <= '0;
    end else begin
      idx_q        <= idx_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tkeep_q    <= m_tkeep_d;
      stat_words_q <= stat_words_d;
      stat_beats_q <= stat_beats_d;
    end
  end

  // Accumulator needs no reset: lanes at or above idx are masked on output.
  always_ff @(posedge aclk) acc_q <= acc_d;

  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign m_tdata    = m_tdata_q;
  assign m_tkeep    = m_tkeep_q;
  assign stat_words = stat_words_q;
  assign stat_beats = stat_beats_q;
endmodule

// File: tb/tb_filter_beat_packer.sv
// Randomized + directed bench for filter_beat_packer against a queue-based packet model.
`timescale 1ns/1ps
module tb_filter_beat_packer;
  logic         aclk = 0, aresetn = 0;
  logic         s_tvalid = 0, s_tlast = 0, m_tready = 1;
  logic [63:0]  s_tdata = '0;
  logic         s_tready, m_tvalid, m_tlast;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic [31:0]  stat_words, stat_beats;

  filter_beat_packer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .stat_words(stat_words), .stat_beats(stat_beats)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [511:0] data; logic [63:0] keep; logic last; } beat_t;

  int tests = 0, fails = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  logic [511:0] part = '0;
  int nw = 0;
  int unsigned mw = 0, mb = 0;
  bit chk_en = 0, in_rst = 0, post_rst = 0;
  int rdy_mode = 0;  // 0: ready=1, 1: ready=0, 2: random

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always begin
    @(posedge aclk); #1;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = 1'b0;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Model: a packet word stream is cut into beats of up to 8 words; compare every cycle.
  initial begin
    forever begin
      @(negedge aclk);
      if (!chk_en) continue;
      if (!aresetn) begin
        if (in_rst) chk("rst_tready", 512'(s_tready), 512'(1));
        in_rst = 1; post_rst = 1;
        exp_q.delete(); part = '0; nw = 0; mw = 0; mb = 0;
        continue;
      end
      in_rst = 0;
      if (post_rst) begin
        chk("rst_tdata", m_tdata, 512'(0));
        chk("rst_tkeep", 512'(m_tkeep), 512'(0));
        chk("rst_tlast", 512'(m_tlast), 512'(0));
        post_rst = 0;
      end
      chk("tvalid", 512'(m_tvalid), 512'(exp_q.size() != 0));
      chk("tready", 512'(s_tready), 512'(exp_q.size() == 0 || m_tready));
      chk("stat_words", 512'(stat_words), 512'(mw));
      chk("stat_beats", 512'(stat_beats), 512'(mb));
      if (exp_q.size() != 0) begin
        chk("tdata", m_tdata, exp_q[0].data);
        chk("tkeep", 512'(m_tkeep), 512'(exp_q[0].keep));
        chk("tlast", 512'(m_tlast), 512'(exp_q[0].last));
      end
      if (m_tvalid && m_tready) begin
        got_q.push_back('{m_tdata, m_tkeep, m_tlast});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        mb++;
      end
      if (s_tvalid && s_tready) begin
        mw++;
        part[nw*64 +: 64] = s_tdata;
        nw++;
        if (nw == 8 || s_tlast) begin
          exp_q.push_back('{part, 64'hFFFF_FFFF_FFFF_FFFF >> (64 - nw*8), s_tlast});
          part = '0; nw = 0;
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic l);
    int n = 0;
    s_tvalid = 1; s_tdata = d; s_tlast = l;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: got no s_tready expected ready within 200 cycles");
        break;
      end
    end
    @(posedge aclk); #1;
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge aclk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || m_tvalid) begin
      @(posedge aclk); #1;
      n++;
      if (n > 500) begin
        tests++; fails++;
        $display("FAIL drain_timeout: got pending beats expected none");
        break;
      end
    end
    idle(1);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge aclk); #1;
    aresetn = 0; s_tvalid = 0; s_tlast = 0;
    idle(cycles);
    aresetn = 1;
  endtask

  logic [511:0] ref_data;
  initial begin
    idle(2);
    chk_en = 1;
    idle(2);
    aresetn = 1;
    idle(1);

    // 16 words, two full beats
    got_q.delete();
    for (int i = 0; i < 16; i++) send_word(64'(i), i == 15);
    drain();
    chk("r21_nbeats", 512'(got_q.size()), 512'(2));
    chk("r21_words", 512'(stat_words), 512'(16));
    chk("r21_beats", 512'(stat_beats), 512'(2));
    if (got_q.size() == 2) begin
      for (int i = 0; i < 8; i++) ref_data[i*64 +: 64] = 64'(i);
      chk("r21_b1_data", got_q[0].data, ref_data);
      chk("r21_b1_keep", 512'(got_q[0].keep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("r21_b1_last", 512'(got_q[0].last), 512'(0));
      for (int i = 0; i < 8; i++) ref_data[i*64 +: 64] = 64'(8 + i);
      chk("r21_b2_data", got_q[1].data, ref_data);
      chk("r21_b2_last", 512'(got_q[1].last), 512'(1));
    end

    // 3-word packet
    got_q.delete();
    send_word(64'hAAAA, 0); send_word(64'hBBBB, 0); send_word(64'hCCCC, 1);
    drain();
    chk("r22_nbeats", 512'(got_q.size()), 512'(1));
    if (got_q.size() == 1) begin
      ref_data = '0;
      ref_data[63:0] = 64'hAAAA; ref_data[127:64] = 64'hBBBB; ref_data[191:128] = 64'hCCCC;
      chk("r22_data", got_q[0].data, ref_data);
      chk("r22_keep", 512'(got_q[0].keep), 512'(64'h0000_0000_00FF_FFFF));
      chk("r22_last", 512'(got_q[0].last), 512'(1));
    end

    // Back-pressure: 12 words offered with m_tready low
    got_q.delete();
    rdy_mode = 1; idle(1);
    for (int i = 0; i < 8; i++) send_word(64'h100 + 64'(i), 0);
    s_tvalid = 1; s_tdata = 64'h108; s_tlast = 0;
    repeat (3) begin
      @(negedge aclk);
      chk("r23_stall_rdy", 512'(s_tready), 512'(0));
    end
    @(posedge aclk); #1;
    rdy_mode = 0;
    for (int i = 8; i < 12; i++) send_word(64'h100 + 64'(i), i == 11);
    drain();
    chk("r23_nbeats", 512'(got_q.size()), 512'(2));
    if (got_q.size() == 2) begin
      chk("r23_b2_keep", 512'(got_q[1].keep), 512'(64'h0000_0000_FFFF_FFFF));
      chk("r23_b2_lane3", 512'(got_q[1].data[255:192]), 512'(64'h10B));
    end

    // Back-to-back single-word packets
    got_q.delete();
    for (int i = 0; i < 6; i++) send_word(64'hD0 + 64'(i), 1);
    drain();
    chk("r24_nbeats", 512'(got_q.size()), 512'(6));
    foreach (got_q[i]) begin
      chk("r24_keep", 512'(got_q[i].keep), 512'(64'hFF));
      chk("r24_data", got_q[i].data, 512'(64'hD0 + 64'(i)));
    end

    // Reset mid-packet
    got_q.delete();
    for (int i = 0; i < 5; i++) send_word(64'hE0 + 64'(i), 0);
    pulse_reset(1);
    for (int i = 0; i < 8; i++) send_word(64'hF0 + 64'(i), i == 7);
    drain();
    chk("r25_nbeats", 512'(got_q.size()), 512'(1));
    chk("r25_words", 512'(stat_words), 512'(8));
    if (got_q.size() == 1) begin
      for (int i = 0; i < 8; i++) ref_data[i*64 +: 64] = 64'hF0 + 64'(i);
      chk("r25_data", got_q[0].data, ref_data);
      chk("r25_last", 512'(got_q[0].last), 512'(1));
    end

    // Randomized traffic with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send_word({$urandom, $urandom}, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    send_word({$urandom, $urandom}, 1);
    rdy_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
